// File: rtl/jtag_stream_fifo.sv
// jtag_stream_fifo: RX/TX byte FIFO pair between a JTAG UART core and a DMA
// engine. A short start-up sequencer holds the block idle for four cycles
// after reset release.
// Optional feature macro: JTAG_FIFO_LEVEL_EN adds the rx_level/tx_level ports.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | start-up counter running, jtag_R=0, no traffic accepted
// ST_RUN  | operational, jtag_R=1, held until reset
module jtag_stream_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              jtag_Dout,
  input  logic [7:0]              jtag_Din,
  input  logic                    jtag_WE,
  input  logic                    jtag_Act,
  output logic                    jtag_R,
  output logic                    jtag_A,
`ifdef JTAG_FIFO_LEVEL_EN
  output logic [$clog2(DEPTH):0]  rx_level,
  output logic [$clog2(DEPTH):0]  tx_level,
`endif
  output logic                    tx_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_init_cnt;
  logic [1:0]   w_init_cnt_nxt;
  logic         w_run;

  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wr_ptr;
  logic [AW-1:0] r_rx_rd_ptr;
  logic [CW-1:0] r_rx_cnt;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic          w_rx_push;
  logic          w_rx_pop;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wr_ptr;
  logic [AW-1:0] r_tx_rd_ptr;
  logic [CW-1:0] r_tx_cnt;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_tx_wr;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          r_tx_ovf;

  // Start-up sequencer state and counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Start-up next state: leave INIT on the fourth cycle after reset release.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_run          = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == 2'd3) begin
          w_state_nxt    = ST_RUN;
          w_init_cnt_nxt = 2'd0;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 2'd1;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
      end
    endcase
  end

  assign jtag_R = w_run;

  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign rx_ready   = w_run & ~w_rx_full;
  assign w_rx_push  = rx_valid & rx_ready;
  assign w_rx_pop   = w_run & jtag_Act & ~jtag_WE & ~w_rx_empty;
  assign jtag_Dout  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd_ptr];

  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_wr    = w_run & jtag_Act & jtag_WE;
  assign w_tx_push  = w_tx_wr & ~w_tx_full;
  assign tx_valid   = ~w_tx_empty;
  assign w_tx_pop   = tx_valid & tx_ready;
  assign tx_data    = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd_ptr];
  assign tx_ovf     = r_tx_ovf;

  assign jtag_A = w_run & (jtag_WE ? ~w_tx_full : ~w_rx_empty);

`ifdef JTAG_FIFO_LEVEL_EN
  assign rx_level = r_rx_cnt;
  assign tx_level = r_tx_cnt;
`endif

  // RX storage write; contents are don't-care while the count says empty.
  always_ff @(posedge Clk) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wr_ptr] <= rx_data;
    end
  end

  // RX pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_cnt    <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + AW'(1);
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // TX storage write from the DMA side.
  always_ff @(posedge Clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wr_ptr] <= jtag_Din;
    end
  end

  // TX pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_cnt    <= '0;
      r_tx_ovf    <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + AW'(1);
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      if (w_tx_wr && w_tx_full) r_tx_ovf <= 1'b1;
    end
  end

endmodule

// File: doc/jtag_stream_fifo.md
JTAG_STREAM_FIFO -- requirements
Module: jtag_stream_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entries per FIFO (power of two, 4..256).
REQ-002 SHALL have port Clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx_data  input  8  byte from the JTAG UART core (host to device).
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  RX FIFO accepts a byte this cycle.
REQ-007 SHALL have port tx_data  output  8  byte to the JTAG UART core (device to host).
REQ-008 SHALL have port tx_valid  output  1  tx_data valid.
REQ-009 SHALL have port tx_ready  input  1  UART core accepts tx_data.
REQ-010 SHALL have port jtag_Dout  output  8  RX FIFO head byte, show-ahead.
REQ-011 SHALL have port jtag_Din  input  8  byte from the DMA engine for TX.
REQ-012 SHALL have port jtag_WE  input  1  direction select: 0 means the DMA reads RX, 1 means the DMA writes TX.
REQ-013 SHALL have port jtag_Act  input  1  one-cycle transfer strobe from the DMA engine.
REQ-014 SHALL have port jtag_R  output  1  block initialised and operational.
REQ-015 SHALL have port jtag_A  output  1  transfer available for the selected direction.
REQ-016 SHALL have port tx_ovf  output  1  sticky flag: a TX write was attempted while the TX FIFO was full.

Function
REQ-017 SHALL contain two independent FIFOs, RX and TX, each DEPTH x 8 bits with an occupancy count 0..DEPTH.
REQ-018 SHALL drive rx_ready = jtag_R and (RX count < DEPTH).
REQ-019 SHALL push rx_data into RX when rx_valid and rx_ready; the byte SHALL appear on jtag_Dout with jtag_A high (jtag_WE=0) on the next cycle when RX was empty.
REQ-020 SHALL drive jtag_A combinationally: (RX count != 0) when jtag_WE=0; (TX count != DEPTH) when jtag_WE=1; 0 while jtag_R=0.
REQ-021 SHALL drive jtag_Dout = RX head entry whenever RX is non-empty, and 8'h00 when RX is empty.
REQ-022 SHALL pop RX when jtag_Act=1, jtag_WE=0 and RX is non-empty; jtag_Act with RX empty SHALL be ignored.
REQ-023 SHALL push jtag_Din into TX when jtag_Act=1, jtag_WE=1 and TX is not full; the byte SHALL appear on tx_data with tx_valid high on the next cycle when TX was empty.
REQ-024 SHALL drop the byte and set tx_ovf when jtag_Act=1, jtag_WE=1 and TX is full; tx_ovf SHALL clear only on reset.
REQ-025 SHALL drive tx_valid = (TX count != 0) and tx_data = TX head entry; SHALL pop TX when tx_valid and tx_ready.
REQ-026 SHALL leave a FIFO's count unchanged on a simultaneous push and pop to that FIFO; data order SHALL be preserved.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH with no lost or duplicated bytes.
REQ-028 SHALL use a start-up state machine with states INIT (4-cycle counter running, jtag_R=0) and RUN (jtag_R=1); INIT SHALL go to RUN after the 4th cycle following reset release; RUN SHALL persist until reset.
REQ-029 SHALL keep rx_ready=0 in INIT and ignore jtag_Act in INIT.

Reset
REQ-030 SHALL, while Reset_n=0 (asynchronously), empty both FIFOs and zero both pointers.
REQ-031 SHALL, while Reset_n=0, drive jtag_R, jtag_A, rx_ready, tx_valid and tx_ovf to 0, and jtag_Dout and tx_data to 8'h00.
REQ-032 SHALL, while Reset_n=0, enter INIT with the counter at 0.
REQ-033 SHALL discard all buffered bytes when reset is asserted mid-transfer.

Configuration
REQ-034 SHALL add output ports rx_level and tx_level (each $clog2(DEPTH)+1 bits, current count, 0 in reset) when JTAG_FIFO_LEVEL_EN is defined.
REQ-035 SHALL, without JTAG_FIFO_LEVEL_EN, omit those ports and all other behaviour SHALL be identical.

Verification
REQ-036 SHALL verify start-up: release Reset_n -> jtag_R=0 for 4 cycles, then 1; rx_ready follows jtag_R.
REQ-037 SHALL verify RX path: push 0x11, 0x22, 0x33 with jtag_WE=0 and Act every cycle -> jtag_Dout gives 0x11, 0x22, 0x33 in order, then jtag_A=0.
REQ-038 SHALL verify RX full: push 16 bytes with no pops (DEPTH=16) -> rx_ready=0; 17th byte held off; one pop -> rx_ready=1 next cycle.
REQ-039 SHALL verify TX overflow: tx_ready=0, write 17 bytes with jtag_WE=1 -> tx_ovf=1, 17th byte absent; drain -> the first 16 bytes appear in order.
REQ-040 SHALL verify simultaneous push and pop: push and pop RX each cycle for 40 cycles with DEPTH=16 -> count constant, pointers wrap, data matches.
REQ-041 SHALL verify mid-operation reset: assert Reset_n=0 with 5 bytes in each FIFO -> tx_valid=0, jtag_A=0 immediately; FIFOs empty after release.
